// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity unit and its helpers.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Turns a raw XOR-reduction into the bit that completes the selected parity.
    function automatic logic parity_fix(input logic par, input logic odd);
        logic result;
        result = par;
        case (odd)
            PAR_ODD:  result = ~par;
            PAR_EVEN: result = par;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/err_sat_counter.sv
// Saturating event counter with synchronous clear taking priority over increment.
module err_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_parity_unit.sv
// Streaming parity generator/checker for framed serial data with a saturating
// error counter; mode and parity sense are latched on the first bit of a frame.
module serial_parity_unit
    import parity_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             odd_sel,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    output logic             out_bit,
    output logic             frame_done,
    output logic             err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            par;
    logic            mode_q;
    logic            odd_q;
    logic            accept;

    assign in_ready = (state != PARITY);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + CW'(1);

    // In check mode the bit after the last data bit is the parity bit, so the
    // DATA state also handles frame completion when the count is already full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            par        <= 1'b0;
            mode_q     <= 1'b0;
            odd_q      <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q    <= mode;
                        odd_q     <= odd_sel;
                        par       <= in_bit;
                        cnt       <= CW'(1);
                        out_valid <= 1'b1;
                        out_bit   <= in_bit;
                        if ((mode == MODE_GEN) && (LAST == CW'(1))) begin
                            state <= PARITY;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if ((mode_q == MODE_CHK) && (cnt == LAST)) begin
                            frame_done <= 1'b1;
                            err        <= parity_fix(par ^ in_bit, odd_q);
                            par        <= 1'b0;
                            cnt        <= '0;
                            state      <= IDLE;
                        end else begin
                            par       <= par ^ in_bit;
                            cnt       <= cnt_inc;
                            out_valid <= 1'b1;
                            out_bit   <= in_bit;
                            if ((mode_q == MODE_GEN) && (cnt_inc == LAST)) begin
                                state <= PARITY;
                            end
                        end
                    end
                end
                PARITY: begin
                    out_valid  <= 1'b1;
                    out_bit    <= parity_fix(par, odd_q);
                    frame_done <= 1'b1;
                    par        <= 1'b0;
                    cnt        <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    err_sat_counter #(
        .CNT_W(CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_cnt),
        .inc   (frame_done && err),
        .count (err_count)
    );

endmodule

// File: tb/tb_serial_parity_unit.sv
// Scoreboard bench for serial_parity_unit: stimulus queues expected output
// events, a negedge monitor pops and compares them as the DUT emits them.
module tb_serial_parity_unit;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic odd_sel = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic clr_cnt = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_bit;
    logic frame_done;
    logic err;
    logic [CNT_W-1:0] err_count;

    typedef struct {
        logic             ov;
        logic             ob;
        logic             fd;
        logic             er;
        logic [CNT_W-1:0] cnt;
    } ev_t;

    ev_t exp_q[$];
    int  asserts = 0;
    int  fails = 0;
    int  notready = 0;
    int  ov_run = 0;
    int  ov_max = 0;

    serial_parity_unit #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .odd_sel    (odd_sel),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .frame_done (frame_done),
        .err        (err),
        .clr_cnt    (clr_cnt),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compares every output event against the head of the scoreboard.
    always @(negedge clk) begin
        ev_t ev;
        if (!rst) begin
            if (!in_ready) notready++;
            if (out_valid) begin
                ov_run++;
                if (ov_run > ov_max) ov_max = ov_run;
            end else begin
                ov_run = 0;
            end
            if (!frame_done) checkOutput("err_without_frame_done", err, 0);
            if (out_valid || frame_done) begin
                if (exp_q.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("[TB] FAIL unexpected_output: out_valid=%0d frame_done=%0d, expected no event at %0t",
                             out_valid, frame_done, $time);
                end else begin
                    ev = exp_q.pop_front();
                    checkOutput("out_valid", out_valid, ev.ov);
                    if (ev.ov) checkOutput("out_bit", out_bit, ev.ob);
                    checkOutput("frame_done", frame_done, ev.fd);
                    checkOutput("err", err, ev.er);
                    if (ev.fd) checkOutput("err_count_at_frame_done", err_count, ev.cnt);
                end
            end
        end
    end

    // Holds a bit on the input until the DUT accepts it; returns at posedge+1.
    task automatic sendBit(input logic b, input int gap);
        int   budget;
        logic rdy;
        budget   = 50;
        in_valid = 1'b1;
        in_bit   = b;
        do begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!rdy && budget > 0);
        if (!rdy) begin
            asserts++;
            fails++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // bits[0] is sent first; exp_last is the generated parity bit or the expected err.
    task automatic applyStimulus(input logic m, input logic o, input logic [0:4] bits,
                                 input logic exp_last, input logic [CNT_W-1:0] cnt_before, input int gap);
        int n;
        n = (m == 1'b1) ? WIDTH + 1 : WIDTH;
        for (int i = 0; i < WIDTH; i++) exp_q.push_back('{1'b1, bits[i], 1'b0, 1'b0, '0});
        if (m == 1'b1) exp_q.push_back('{1'b0, 1'b0, 1'b1, exp_last, cnt_before});
        else           exp_q.push_back('{1'b1, exp_last, 1'b1, 1'b0, cnt_before});
        mode    = m;
        odd_sel = o;
        for (int i = 0; i < n; i++) begin
            sendBit(bits[i], (i == n - 1) ? 0 : gap);
            if (i == 0) begin
                mode    = ~m;
                odd_sel = ~o;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_bit", out_bit, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_err_count", err_count, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", in_ready, 1);

        // Generate odd 1011: parity 0, five contiguous valid cycles, one stall.
        notready = 0;
        ov_max   = 0;
        applyStimulus(1'b0, 1'b1, 5'b10110, 1'b0, 2'd0, 0);
        idleCycles(3);
        checkOutput("gen_not_ready_cycles", notready, 1);
        checkOutput("gen_contiguous_valid", ov_max, 5);

        // Generate 0000 even -> 0, odd -> 1.
        applyStimulus(1'b0, 1'b0, 5'b00000, 1'b0, 2'd0, 0);
        applyStimulus(1'b0, 1'b1, 5'b00000, 1'b1, 2'd0, 0);
        idleCycles(2);

        // Check odd: 11001 good, 11000 bad.
        applyStimulus(1'b1, 1'b1, 5'b11001, 1'b0, 2'd0, 0);
        idleCycles(2);
        checkOutput("chk_good_count", err_count, 0);
        applyStimulus(1'b1, 1'b1, 5'b11000, 1'b1, 2'd0, 0);
        idleCycles(2);
        checkOutput("chk_bad_count", err_count, 1);

        // Check even with 3-cycle gaps: 10001 good.
        applyStimulus(1'b1, 1'b0, 5'b10001, 1'b0, 2'd1, 3);
        idleCycles(2);
        checkOutput("chk_gap_count", err_count, 1);

        // Saturation with back-to-back bad frames, then clear colliding with an increment.
        clr_cnt = 1'b1;
        idleCycles(1);
        clr_cnt = 1'b0;
        checkOutput("clr_count", err_count, 0);
        applyStimulus(1'b1, 1'b0, 5'b10000, 1'b1, 2'd0, 0);
        applyStimulus(1'b1, 1'b0, 5'b10000, 1'b1, 2'd1, 0);
        applyStimulus(1'b1, 1'b0, 5'b10000, 1'b1, 2'd2, 0);
        applyStimulus(1'b1, 1'b0, 5'b10000, 1'b1, 2'd3, 0);
        applyStimulus(1'b1, 1'b0, 5'b10000, 1'b1, 2'd3, 0);
        applyStimulus(1'b1, 1'b0, 5'b10000, 1'b1, 2'd3, 0);
        clr_cnt = 1'b1;
        idleCycles(1);
        clr_cnt = 1'b0;
        checkOutput("clr_priority_count", err_count, 0);
        idleCycles(2);
        checkOutput("clr_hold_count", err_count, 0);

        // Reset after two data bits, then a clean frame.
        mode    = 1'b0;
        odd_sel = 1'b1;
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, '0});
        sendBit(1'b0, 0);
        sendBit(1'b1, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_out_bit", out_bit, 0);
        checkOutput("midreset_frame_done", frame_done, 0);
        checkOutput("midreset_in_ready", in_ready, 1);
        checkOutput("midreset_err_count", err_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 5'b10110, 1'b0, 2'd0, 0);

        budget = 50;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        idleCycles(2);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
